// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - register-file write port arbiter with aux-result scoreboard and starvation stall.
// Optional: SCOREBOARD_BYPASS_EN lets busy_x clear in the same cycle the aux result is written.
module regfile_write_arbiter #(
  parameter int ADDR_W       = 5,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pipe_we,
  input  logic [ADDR_W-1:0] pipe_waddr,
  input  logic [DATA_W-1:0] pipe_wdata,
  input  logic              aux_valid,
  input  logic [ADDR_W-1:0] aux_addr,
  input  logic [DATA_W-1:0] aux_data,
  output logic              aux_ready,
  input  logic              issue_en,
  input  logic [ADDR_W-1:0] issue_addr,
  input  logic [ADDR_W-1:0] query_addr_1,
  input  logic [ADDR_W-1:0] query_addr_2,
  output logic              busy_1,
  output logic              busy_2,
  output logic              stall_req,
  output logic              rf_write_en,
  output logic [ADDR_W-1:0] rf_write_addr,
  output logic [DATA_W-1:0] rf_write_data
);

  localparam int NREG  = 1 << ADDR_W;
  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] W_LIMIT = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_FORCE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             r_stall_req;
  logic [NREG-1:0]  r_sb;
  logic [NREG-1:0]  w_sb_nxt;

  logic w_pipe_sel;
  logic w_fire;
  logic w_blocked;
  logic w_busy_1;
  logic w_busy_2;

  // Pipeline writeback always wins; aux only gets the port on cycles the pipeline leaves free.
  assign w_pipe_sel = rst & pipe_we;
  assign w_fire     = rst & ~pipe_we & aux_valid;
  assign w_blocked  = aux_valid & ~w_fire;
  assign w_cnt_inc  = r_cnt + 4'd1;

  assign aux_ready   = w_fire;
  assign rf_write_en = w_pipe_sel | w_fire;

  always_comb begin
    rf_write_addr = '0;
    rf_write_data = '0;
    if (w_pipe_sel) begin
      rf_write_addr = pipe_waddr;
      rf_write_data = pipe_wdata;
    end else if (w_fire) begin
      rf_write_addr = aux_addr;
      rf_write_data = aux_data;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_blocked) begin
          w_cnt_nxt   = 4'd1;
          w_state_nxt = (W_LIMIT == 4'd1) ? S_FORCE : S_WAIT;
        end
      end
      S_WAIT: begin
        if (w_fire || !aux_valid) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = w_cnt_inc;
          if (w_cnt_inc == W_LIMIT) begin
            w_state_nxt = S_FORCE;
          end
        end
      end
      S_FORCE: begin
        // Withdrawn aux request also releases the freeze so the pipeline cannot lock up.
        if (w_fire || !aux_valid) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Clear on fire first, then set on issue, so a same-address reissue stays pending.
  always_comb begin
    w_sb_nxt = r_sb;
    if (w_fire) begin
      w_sb_nxt[aux_addr] = 1'b0;
    end
    if (issue_en && (issue_addr != '0)) begin
      w_sb_nxt[issue_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_stall_req <= 1'b0;
      r_sb        <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_stall_req <= (w_state_nxt == S_FORCE);
      r_sb        <= w_sb_nxt;
    end
  end

  assign stall_req = r_stall_req;

`ifdef SCOREBOARD_BYPASS_EN
  assign w_busy_1 = r_sb[query_addr_1] & ~(w_fire && (aux_addr == query_addr_1));
  assign w_busy_2 = r_sb[query_addr_2] & ~(w_fire && (aux_addr == query_addr_2));
`else
  assign w_busy_1 = r_sb[query_addr_1];
  assign w_busy_2 = r_sb[query_addr_2];
`endif

  assign busy_1 = rst & w_busy_1;
  assign busy_2 = rst & w_busy_2;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - directed vectors with a queued scoreboard checked by a negedge monitor.
module tb_regfile_write_arbiter;

  logic        clk;
  logic        rst;
  logic        pipe_we;
  logic [4:0]  pipe_waddr;
  logic [31:0] pipe_wdata;
  logic        aux_valid;
  logic [4:0]  aux_addr;
  logic [31:0] aux_data;
  logic        aux_ready;
  logic        issue_en;
  logic [4:0]  issue_addr;
  logic [4:0]  query_addr_1;
  logic [4:0]  query_addr_2;
  logic        busy_1;
  logic        busy_2;
  logic        stall_req;
  logic        rf_write_en;
  logic [4:0]  rf_write_addr;
  logic [31:0] rf_write_data;

  typedef struct {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        rdy;
    logic        stall;
    logic        b1;
    logic        b2;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  regfile_write_arbiter #(.ADDR_W(5), .DATA_W(32), .STARVE_LIMIT(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .pipe_we       (pipe_we),
    .pipe_waddr    (pipe_waddr),
    .pipe_wdata    (pipe_wdata),
    .aux_valid     (aux_valid),
    .aux_addr      (aux_addr),
    .aux_data      (aux_data),
    .aux_ready     (aux_ready),
    .issue_en      (issue_en),
    .issue_addr    (issue_addr),
    .query_addr_1  (query_addr_1),
    .query_addr_2  (query_addr_2),
    .busy_1        (busy_1),
    .busy_2        (busy_2),
    .stall_req     (stall_req),
    .rf_write_en   (rf_write_en),
    .rf_write_addr (rf_write_addr),
    .rf_write_data (rf_write_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("rf_write_en",   {31'd0, rf_write_en}, {31'd0, e.we});
      chk("rf_write_addr", {27'd0, rf_write_addr}, {27'd0, e.addr});
      chk("rf_write_data", rf_write_data, e.data);
      chk("aux_ready",     {31'd0, aux_ready}, {31'd0, e.rdy});
      chk("stall_req",     {31'd0, stall_req}, {31'd0, e.stall});
      chk("busy_1",        {31'd0, busy_1}, {31'd0, e.b1});
      chk("busy_2",        {31'd0, busy_2}, {31'd0, e.b2});
    end
  end

  // One cycle: drive inputs just after the posedge, queue the hand-computed expectation.
  task automatic cyc(
    input logic r, input logic pwe, input logic [4:0] pa, input logic [31:0] pd,
    input logic av, input logic [4:0] aa, input logic [31:0] ad,
    input logic ie, input logic [4:0] ia, input logic [4:0] q1, input logic [4:0] q2,
    input logic ewe, input logic [4:0] ea, input logic [31:0] ed,
    input logic erdy, input logic est, input logic eb1, input logic eb2);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; pipe_we = pwe; pipe_waddr = pa; pipe_wdata = pd;
    aux_valid = av; aux_addr = aa; aux_data = ad;
    issue_en = ie; issue_addr = ia; query_addr_1 = q1; query_addr_2 = q2;
    e.we = ewe; e.addr = ea; e.data = ed; e.rdy = erdy; e.stall = est; e.b1 = eb1; e.b2 = eb2;
    exp_q.push_back(e);
  endtask

  initial begin
    rst = 1'b0; pipe_we = 1'b0; pipe_waddr = '0; pipe_wdata = '0;
    aux_valid = 1'b0; aux_addr = '0; aux_data = '0;
    issue_en = 1'b0; issue_addr = '0; query_addr_1 = '0; query_addr_2 = '0;

    // reset then idle sweep of every query address
    cyc(0, 0,0,0,          0,0,0,          0,0, 0,0,   0,0,0,          0,0,0,0);
    cyc(0, 0,0,0,          0,0,0,          0,0, 0,0,   0,0,0,          0,0,0,0);
    for (int i = 0; i < 32; i++)
      cyc(1, 0,0,0,        0,0,0,          0,0, 5'(i),5'(31-i), 0,0,0,    0,0,0,0);

    // pipeline beats aux, then aux fires
    cyc(1, 1,5,32'h1234,   1,7,32'hAAAA,   0,0, 0,0,   1,5,32'h1234,   0,0,0,0);
    cyc(1, 0,0,0,          1,7,32'hAAAA,   0,0, 0,0,   1,7,32'hAAAA,   1,0,0,0);
    cyc(1, 0,0,0,          0,0,0,          0,0, 0,0,   0,0,0,          0,0,0,0);

    // starvation: four blocked cycles reach FORCE
    cyc(1, 1,1,32'h11,     1,2,32'h22,     0,0, 0,0,   1,1,32'h11,     0,0,0,0);
    cyc(1, 1,1,32'h11,     1,2,32'h22,     0,0, 0,0,   1,1,32'h11,     0,0,0,0);
    cyc(1, 1,1,32'h11,     1,2,32'h22,     0,0, 0,0,   1,1,32'h11,     0,0,0,0);
    cyc(1, 1,1,32'h11,     1,2,32'h22,     0,0, 0,0,   1,1,32'h11,     0,0,0,0);
    cyc(1, 1,1,32'h11,     1,2,32'h22,     0,0, 0,0,   1,1,32'h11,     0,1,0,0);
    cyc(1, 0,0,0,          1,2,32'h22,     0,0, 0,0,   1,2,32'h22,     1,1,0,0);
    cyc(1, 0,0,0,          0,0,0,          0,0, 0,0,   0,0,0,          0,0,0,0);

    // scoreboard set/clear on addr 9
    cyc(1, 0,0,0,          0,0,0,          1,9, 9,0,   0,0,0,          0,0,0,0);
    cyc(1, 0,0,0,          0,0,0,          0,0, 9,0,   0,0,0,          0,0,1,0);
    cyc(1, 0,0,0,          1,9,32'h99,     0,0, 9,0,   1,9,32'h99,     1,0,1,0);
    cyc(1, 0,0,0,          0,0,0,          0,0, 9,0,   0,0,0,          0,0,0,0);

    // same-address set/clear keeps busy; addr 0 never busy; different addresses both apply
    cyc(1, 0,0,0,          0,0,0,          1,3, 3,0,   0,0,0,          0,0,0,0);
    cyc(1, 0,0,0,          1,3,32'h33,     1,3, 3,0,   1,3,32'h33,     1,0,1,0);
    cyc(1, 0,0,0,          0,0,0,          1,0, 3,0,   0,0,0,          0,0,1,0);
    cyc(1, 0,0,0,          1,3,32'h44,     1,4, 3,0,   1,3,32'h44,     1,0,1,0);
    cyc(1, 0,0,0,          0,0,0,          0,0, 3,4,   0,0,0,          0,0,0,1);
    cyc(1, 0,0,0,          1,4,32'h55,     0,0, 7,4,   1,4,32'h55,     1,0,0,1);
    cyc(1, 0,0,0,          0,0,0,          0,0, 7,4,   0,0,0,          0,0,0,0);

    // reset while in FORCE with bit 12 pending
    cyc(1, 0,0,0,          0,0,0,          1,12, 12,0, 0,0,0,          0,0,0,0);
    cyc(1, 1,1,32'h11,     1,2,32'h22,     0,0, 12,0,  1,1,32'h11,     0,0,1,0);
    cyc(1, 1,1,32'h11,     1,2,32'h22,     0,0, 12,0,  1,1,32'h11,     0,0,1,0);
    cyc(1, 1,1,32'h11,     1,2,32'h22,     0,0, 12,0,  1,1,32'h11,     0,0,1,0);
    cyc(1, 1,1,32'h11,     1,2,32'h22,     0,0, 12,0,  1,1,32'h11,     0,0,1,0);
    cyc(1, 1,1,32'h11,     1,2,32'h22,     0,0, 12,0,  1,1,32'h11,     0,1,1,0);
    cyc(0, 1,1,32'h11,     1,2,32'h22,     0,0, 12,0,  0,0,0,          0,1,0,0);
    cyc(1, 0,0,0,          0,0,0,          0,0, 12,0,  0,0,0,          0,0,0,0);
    cyc(1, 1,1,32'h11,     1,2,32'h22,     0,0, 12,0,  1,1,32'h11,     0,0,0,0);
    cyc(1, 1,1,32'h11,     1,2,32'h22,     0,0, 12,0,  1,1,32'h11,     0,0,0,0);
    cyc(1, 0,0,0,          1,2,32'h22,     0,0, 12,0,  1,2,32'h22,     1,0,0,0);
    cyc(1, 0,0,0,          0,0,0,          0,0, 12,0,  0,0,0,          0,0,0,0);

    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
    if (exp_q.size() > 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
